dram_req_arbiter: RTL and testbench
===================================

DRAM_REQ_ARBITER -- requirements
Module: dram_req_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, meaning the number of requester ports (2..8).
REQ-002 The block SHALL have parameter ADDR_W, default 32, meaning the address width.
REQ-003 The block SHALL have parameter DATA_W, default 32, meaning the data width.
REQ-004 The block SHALL have one clock; reset is synchronous and active-low (CLK, nRST).
REQ-005 CLK  input  1  clock; all state changes on its rising edge.
REQ-006 nRST  input  1  synchronous active-low reset.
REQ-007 req_ren  input  NREQ  per-port read request, level, held until done.
REQ-008 req_wen  input  NREQ  per-port write request, level, held until done.
REQ-009 req_addr  input  NREQ*ADDR_W  per-port address; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-010 req_wdata  input  NREQ*DATA_W  per-port write data, packed the same way.
REQ-011 req_gnt  output  NREQ  one-hot; the port currently owning the DRAM.
REQ-012 req_done  output  NREQ  one-hot, single-cycle completion pulse.
REQ-013 req_rdata  output  DATA_W  read data, valid in the req_done cycle.
REQ-014 dREN  output  1  read request to the DRAM command FSM.
REQ-015 dWEN  output  1  write request to the DRAM command FSM.
REQ-016 dAddr  output  ADDR_W  latched address of the granted port.
REQ-017 dWdata  output  DATA_W  latched write data of the granted port.
REQ-018 ram_wait  input  1  from the command FSM; low for one cycle marks access completion.
REQ-019 ram_rdata  input  DATA_W  read data from DRAM, valid while ram_wait is low.
REQ-020 arb_busy  output  1  high in GRANT and DONE states.

Function
REQ-021 States SHALL be IDLE, GRANT and DONE.
REQ-022 IDLE: a port is active if req_ren[i] or req_wen[i] is set; if no port is active, the block SHALL stay in IDLE.
REQ-023 IDLE: if any port is active, the block SHALL select the first active port at or after rr_ptr, wrapping modulo NREQ, and go to GRANT at the next edge.
REQ-024 On the IDLE->GRANT edge the block SHALL latch the winner index, op, dAddr and dWdata; later changes on the requester inputs SHALL be ignored until DONE.
REQ-025 If req_ren[i] and req_wen[i] are both set on the winning port, the op SHALL be a write.
REQ-026 On the IDLE->GRANT edge rr_ptr SHALL update to (winner+1) mod NREQ.
REQ-027 GRANT: req_gnt SHALL be one-hot on the winner, and dWEN or dREN SHALL follow the latched op while ram_wait is 1.
REQ-028 GRANT: in a cycle with ram_wait==0, dREN and dWEN SHALL be forced low combinationally in that same cycle, so the FSM returning to IDLE samples no stale request.
REQ-029 GRANT: with ram_wait==0, the block SHALL register ram_rdata into req_rdata (reads only; writes leave it unchanged) and go to DONE.
REQ-030 DONE: lasts exactly one cycle, with req_done[winner]=1, req_gnt still on the winner, dREN=dWEN=0, then IDLE.
REQ-031 Minimum spacing SHALL hold: a new grant is registered no earlier than the edge ending DONE, so back-to-back accesses have at least one request-free cycle.
REQ-032 A requester dropping its request during GRANT SHALL NOT abort the access; its done pulse SHALL still be issued.
REQ-033 Fairness: a continuously requesting port SHALL be granted within NREQ grants.
REQ-034 req_gnt and req_done SHALL never have more than one bit set.
REQ-035 ram_wait is high throughout DRAM power-up and refresh; the block SHALL hold GRANT without a timeout until ram_wait falls.

Reset
REQ-036 With nRST low at a rising edge, the state SHALL become IDLE and rr_ptr 0.
REQ-037 Under that reset, req_gnt, req_done, dREN, dWEN and arb_busy SHALL be 0.
REQ-038 Under that reset, dAddr, dWdata and req_rdata SHALL be 0.
REQ-039 Reset mid-access SHALL discard the in-flight grant with no done pulse.
REQ-040 Reset SHALL NOT be sampled asynchronously; nRST low between edges SHALL have no effect.

Verification
REQ-041 Single read, NREQ=4: port 2 ren, addr 0x100; ram_wait low 5 cycles after grant with rdata 0xDEADBEEF -> dREN high 5 cycles, req_done=4'b0100 one cycle, req_rdata=0xDEADBEEF.
REQ-042 Round-robin: all 4 ports request continuously -> grant order 0,1,2,3,0 and rr_ptr wraps 3->0.
REQ-043 Same-cycle ren+wen on port 1 -> dWEN=1, dREN=0, and req_rdata unchanged after done.
REQ-044 ram_wait low cycle -> dREN/dWEN low in that same cycle; the next grant's dREN rises no earlier than 2 cycles later.
REQ-045 Port 3 drops request mid-GRANT and addr changes -> dAddr holds the latched value and req_done[3] still pulses.
REQ-046 nRST low during GRANT -> next cycle all outputs 0, no req_done, and the next grant starts searching from port 0.

Source files
------------

// File: rtl/dram_req_arbiter.sv
// Round-robin arbiter that grants one requester port at a time to the DRAM
// command FSM. The request is latched at grant time and held until the access completes.
module dram_req_arbiter #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [NREQ-1:0]          req_ren,
    input  logic [NREQ-1:0]          req_wen,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_wdata,
    output logic [NREQ-1:0]          req_gnt,
    output logic [NREQ-1:0]          req_done,
    output logic [DATA_W-1:0]        req_rdata,
    output logic                     dREN,
    output logic                     dWEN,
    output logic [ADDR_W-1:0]        dAddr,
    output logic [DATA_W-1:0]        dWdata,
    input  logic                     ram_wait,
    input  logic [DATA_W-1:0]        ram_rdata,
    output logic                     arb_busy
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic [NREQ-1:0]     active_s;
    logic                found_s;
    logic [IDX_W-1:0]    pick_s;
    logic [IDX_W-1:0]    rr_next_s;
    logic [NREQ-1:0]     win_onehot_s;

    // Round-robin search: first active port at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        logic [IDX_W:0] idx_v;
        logic [IDX_W:0] nxt_v;
        active_s  = req_ren | req_wen;
        found_s   = 1'b0;
        pick_s    = '0;
        idx_v     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx_v = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            if (idx_v >= (IDX_W+1)'(NREQ)) begin
                idx_v = idx_v - (IDX_W+1)'(NREQ);
            end else begin
                idx_v = idx_v;
            end
            if (!found_s && active_s[idx_v[IDX_W-1:0]]) begin
                found_s = 1'b1;
                pick_s  = idx_v[IDX_W-1:0];
            end else begin
                found_s = found_s;
            end
        end
        nxt_v = {1'b0, pick_s} + {{IDX_W{1'b0}}, 1'b1};
        if (nxt_v >= (IDX_W+1)'(NREQ)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = nxt_v[IDX_W-1:0];
        end
    end

    // Next-state logic: latch the winner's op/address/data on grant, capture read data on completion.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        win_d    = win_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (found_s) begin
                    state_d  = S_GRANT;
                    win_d    = pick_s;
                    wr_d     = req_wen[pick_s];
                    addr_d   = req_addr[int'(pick_s)*ADDR_W +: ADDR_W];
                    wdata_d  = req_wdata[int'(pick_s)*DATA_W +: DATA_W];
                    rr_ptr_d = rr_next_s;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_GRANT: begin
                if (!ram_wait) begin
                    state_d = S_DONE;
                    if (!wr_q) begin
                        rdata_d = ram_rdata;
                    end else begin
                        rdata_d = rdata_q;
                    end
                end else begin
                    state_d = S_GRANT;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            win_q    <= '0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            win_q    <= win_d;
            wr_q     <= wr_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
        end
    end

    // Outputs decode from registered state; strobes drop in the same cycle ram_wait falls.
    always_comb begin
        win_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << win_q;
        req_gnt      = (state_q != S_IDLE) ? win_onehot_s : '0;
        req_done     = (state_q == S_DONE) ? win_onehot_s : '0;
        dREN         = (state_q == S_GRANT) && ram_wait && !wr_q;
        dWEN         = (state_q == S_GRANT) && ram_wait && wr_q;
        arb_busy     = (state_q != S_IDLE);
        dAddr        = addr_q;
        dWdata       = wdata_q;
        req_rdata    = rdata_q;
    end

endmodule

// File: tb/tb_dram_req_arbiter.sv
// Directed testbench for dram_req_arbiter (NREQ=4) with hand-computed expected values.
module tb_dram_req_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 32;
    localparam int DW   = 32;

    logic                 CLK = 1'b0;
    logic                 nRST;
    logic [NREQ-1:0]      req_ren, req_wen;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ-1:0]      req_gnt, req_done;
    logic [DW-1:0]        req_rdata;
    logic                 dREN, dWEN;
    logic [AW-1:0]        dAddr;
    logic [DW-1:0]        dWdata;
    logic                 ram_wait;
    logic [DW-1:0]        ram_rdata;
    logic                 arb_busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_rdata;

    dram_req_arbiter #(.NREQ(NREQ), .ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_ren(req_ren), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_gnt(req_gnt), .req_done(req_done), .req_rdata(req_rdata),
        .dREN(dREN), .dWEN(dWEN), .dAddr(dAddr), .dWdata(dWdata),
        .ram_wait(ram_wait), .ram_rdata(ram_rdata), .arb_busy(arb_busy)
    );

    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] d);
        req_ren[p] = rd;
        req_wen[p] = wr;
        req_addr[p*AW +: AW]  = a;
        req_wdata[p*DW +: DW] = d;
    endtask

    // One complete access: wait for grant, hold ram_wait high nwait cycles, complete, check DONE and gap.
    task automatic run_access(input string tag, input logic [3:0] exp_gnt, input logic exp_wr,
                              input int nwait, input logic [31:0] exp_addr,
                              input logic [31:0] rd, input bit drop);
        int   n;
        int   hi;
        logic got;
        n = 0; hi = 0; got = 1'b0;
        while (!got && n < 8) begin
            @(negedge CLK); #1;
            if (req_gnt != 4'b0000) got = 1'b1;
            n++;
        end
        check_val({tag, " grant seen"}, 64'(got), 64'd1);
        check_val({tag, " gnt"}, 64'(req_gnt), 64'(exp_gnt));
        check_val({tag, " dAddr"}, 64'(dAddr), 64'(exp_addr));
        for (int i = 0; i < nwait; i++) begin
            if (i > 0) begin
                @(negedge CLK); #1;
            end
            if (exp_wr ? dWEN : dREN) hi = hi + 1;
            if (exp_wr ? dREN : dWEN) hi = hi + 100;
        end
        check_val({tag, " strobe cycles"}, 64'(hi), 64'(nwait));
        @(negedge CLK); #1;
        ram_wait  = 1'b0;
        ram_rdata = rd;
        #1;
        check_val({tag, " strobes off when wait low"}, 64'({dREN, dWEN}), 64'd0);
        @(negedge CLK);
        ram_wait = 1'b1;
        if (drop) begin
            req_ren = '0;
            req_wen = '0;
        end
        #1;
        if (!exp_wr) exp_rdata = rd;
        check_val({tag, " done"}, 64'(req_done), 64'(exp_gnt));
        check_val({tag, " gnt in done"}, 64'(req_gnt), 64'(exp_gnt));
        check_val({tag, " rdata"}, 64'(req_rdata), 64'(exp_rdata));
        check_val({tag, " done strobes/busy"}, 64'({dREN, dWEN, arb_busy}), 64'(3'b001));
        @(negedge CLK); #1;
        check_val({tag, " gap cycle"}, 64'({req_gnt, req_done, dREN, dWEN}), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST      = 1'b0;
        req_ren   = '0;
        req_wen   = '0;
        req_addr  = '0;
        req_wdata = '0;
        ram_wait  = 1'b1;
        ram_rdata = '0;
        exp_rdata = 32'h0;
        repeat (2) @(posedge CLK);
        @(negedge CLK); #1;
        check_val("reset ctrl", 64'({req_gnt, req_done, dREN, dWEN, arb_busy}), 64'd0);
        check_val("reset data", 64'({dAddr, dWdata}), 64'd0);
        check_val("reset rdata", 64'(req_rdata), 64'd0);
        nRST = 1'b1;

        // Single read on port 2, five wait cycles
        set_port(2, 1'b1, 1'b0, 32'h100, 32'h0);
        run_access("rd_p2", 4'b0100, 1'b0, 5, 32'h100, 32'hDEADBEEF, 1'b1);

        // Round robin from a freshly reset pointer
        nRST = 1'b0;
        @(negedge CLK); #1;
        nRST = 1'b1;
        check_val("rr reset rdata", 64'(req_rdata), 64'd0);
        exp_rdata = 32'h0;
        set_port(0, 1'b1, 1'b0, 32'h1000, 32'h0);
        set_port(1, 1'b1, 1'b0, 32'h1100, 32'h0);
        set_port(2, 1'b1, 1'b0, 32'h1200, 32'h0);
        set_port(3, 1'b1, 1'b0, 32'h1300, 32'h0);
        run_access("rr0", 4'b0001, 1'b0, 1, 32'h1000, 32'hA0A0A0A0, 1'b0);
        run_access("rr1", 4'b0010, 1'b0, 1, 32'h1100, 32'hA1A1A1A1, 1'b0);
        run_access("rr2", 4'b0100, 1'b0, 2, 32'h1200, 32'hA2A2A2A2, 1'b0);
        run_access("rr3", 4'b1000, 1'b0, 1, 32'h1300, 32'hA3A3A3A3, 1'b0);
        run_access("rr4", 4'b0001, 1'b0, 1, 32'h1000, 32'hA4A4A4A4, 1'b1);

        // Port 1 with ren+wen together is a write; read data must not change
        set_port(1, 1'b1, 1'b1, 32'h200, 32'h12345678);
        run_access("rw_p1", 4'b0010, 1'b1, 3, 32'h200, 32'hBADBAD00, 1'b1);
        check_val("rw_p1 dWdata", 64'(dWdata), 64'h12345678);

        // Port 3 drops its request mid-grant and changes address
        set_port(3, 1'b1, 1'b0, 32'h300, 32'h0);
        @(negedge CLK); #1;
        check_val("drop gnt", 64'(req_gnt), 64'(4'b1000));
        set_port(3, 1'b0, 1'b0, 32'h999, 32'h0);
        #1;
        check_val("drop dAddr held", 64'(dAddr), 64'h300);
        @(negedge CLK); #1;
        check_val("drop still reading", 64'({req_gnt, dREN}), 64'({4'b1000, 1'b1}));
        ram_wait  = 1'b0;
        ram_rdata = 32'hCAFEF00D;
        @(negedge CLK);
        ram_wait = 1'b1;
        #1;
        exp_rdata = 32'hCAFEF00D;
        check_val("drop done", 64'(req_done), 64'(4'b1000));
        check_val("drop rdata", 64'(req_rdata), 64'(exp_rdata));
        @(negedge CLK); #1;
        check_val("drop done cleared", 64'(req_done), 64'd0);

        // Reset during GRANT: glitch between edges ignored, sampled reset clears everything
        set_port(1, 1'b1, 1'b0, 32'h400, 32'h0);
        @(negedge CLK); #1;
        check_val("rst pre gnt", 64'(req_gnt), 64'(4'b0010));
        nRST = 1'b0;
        #2;
        nRST = 1'b1;
        @(negedge CLK); #1;
        check_val("rst glitch ignored", 64'({req_gnt, arb_busy}), 64'({4'b0010, 1'b1}));
        nRST     = 1'b0;
        ram_wait = 1'b0;
        @(negedge CLK); #1;
        check_val("rst mid ctrl", 64'({req_gnt, req_done, dREN, dWEN, arb_busy}), 64'd0);
        check_val("rst mid data", 64'({dAddr, dWdata}), 64'd0);
        check_val("rst mid rdata", 64'(req_rdata), 64'd0);
        exp_rdata = 32'h0;
        ram_wait  = 1'b1;
        nRST      = 1'b1;
        set_port(3, 1'b1, 1'b0, 32'h500, 32'h0);
        run_access("rst_next", 4'b0010, 1'b0, 1, 32'h400, 32'h11112222, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
